// File: rtl/enigma_pkg.sv
// Shared types, constants and helpers for the Enigma rotor stepping controller.
package enigma_pkg;

  localparam int unsigned ALPHABET = 26;
  localparam int unsigned POS_W    = 5;
  localparam int unsigned CNT_W    = 4;

  typedef logic [POS_W-1:0] pos_t;

  localparam pos_t LAST_POS = pos_t'(ALPHABET - 1);

  localparam pos_t LTR_A = pos_t'(0);
  localparam pos_t LTR_B = pos_t'(1);
  localparam pos_t LTR_C = pos_t'(2);
  localparam pos_t LTR_D = pos_t'(3);
  localparam pos_t LTR_E = pos_t'(4);
  localparam pos_t LTR_F = pos_t'(5);
  localparam pos_t LTR_G = pos_t'(6);
  localparam pos_t LTR_H = pos_t'(7);
  localparam pos_t LTR_I = pos_t'(8);
  localparam pos_t LTR_J = pos_t'(9);
  localparam pos_t LTR_K = pos_t'(10);
  localparam pos_t LTR_L = pos_t'(11);
  localparam pos_t LTR_M = pos_t'(12);
  localparam pos_t LTR_N = pos_t'(13);
  localparam pos_t LTR_O = pos_t'(14);
  localparam pos_t LTR_P = pos_t'(15);
  localparam pos_t LTR_Q = pos_t'(16);
  localparam pos_t LTR_R = pos_t'(17);
  localparam pos_t LTR_S = pos_t'(18);
  localparam pos_t LTR_T = pos_t'(19);
  localparam pos_t LTR_U = pos_t'(20);
  localparam pos_t LTR_V = pos_t'(21);
  localparam pos_t LTR_W = pos_t'(22);
  localparam pos_t LTR_X = pos_t'(23);
  localparam pos_t LTR_Y = pos_t'(24);
  localparam pos_t LTR_Z = pos_t'(25);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_ENCODE
  } state_t;

  // Advance one letter, wrapping Z back to A.
  function automatic pos_t inc26(input pos_t p);
    return (p == LAST_POS) ? LTR_A : p + pos_t'(1);
  endfunction

endpackage

// File: rtl/enigma_pos_counter.sv
// Mod-26 rotor position register with preload, step enable and notch detect.
module enigma_pos_counter
  import enigma_pkg::*;
#(
  parameter pos_t NOTCH = LTR_A
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  pos_t load_val,
  input  logic step,
  output pos_t pos,
  output logic at_notch
);

  // Out-of-range preload values fold to A.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= LTR_A;
    end else if (load) begin
      pos <= (load_val > LAST_POS) ? LTR_A : load_val;
    end else if (step) begin
      pos <= inc26(pos);
    end
  end

  assign at_notch = (pos == NOTCH);

endmodule

// File: rtl/enigma_step_controller.sv
// Keypress sequencer: steps three rotors with double-step turnover, then strobes encode.
module enigma_step_controller
  import enigma_pkg::*;
#(
  parameter int unsigned NOTCH_L       = 16,
  parameter int unsigned NOTCH_M       = 4,
  parameter int unsigned NOTCH_R       = 21,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic key_valid,
  output logic key_ready,
  input  logic load,
  input  pos_t load_pos_l,
  input  pos_t load_pos_m,
  input  pos_t load_pos_r,
  output pos_t pos_l,
  output pos_t pos_m,
  output pos_t pos_r,
  output logic rotate_l,
  output logic rotate_m,
  output logic rotate_r,
  output logic enc_strobe,
  output logic busy
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               load_en;
  logic               notch_m, notch_r;
  logic               unused_notch_l;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stepping is decided from the positions held during STEP, i.e. those at STEP entry.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_en    = 1'b0;
    key_ready  = 1'b0;
    rotate_l   = 1'b0;
    rotate_m   = 1'b0;
    rotate_r   = 1'b0;
    enc_strobe = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        key_ready = !load;
        load_en   = load;
        if (key_valid && !load) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        rotate_r  = 1'b1;
        rotate_m  = notch_r || notch_m;
        rotate_l  = notch_m;
        cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_ENCODE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_ENCODE: begin
        enc_strobe = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  enigma_pos_counter #(.NOTCH(pos_t'(NOTCH_L))) u_rotor_l (
    .clock    (clock),
    .reset    (reset),
    .load     (load_en),
    .load_val (load_pos_l),
    .step     (rotate_l),
    .pos      (pos_l),
    .at_notch (unused_notch_l)
  );

  enigma_pos_counter #(.NOTCH(pos_t'(NOTCH_M))) u_rotor_m (
    .clock    (clock),
    .reset    (reset),
    .load     (load_en),
    .load_val (load_pos_m),
    .step     (rotate_m),
    .pos      (pos_m),
    .at_notch (notch_m)
  );

  enigma_pos_counter #(.NOTCH(pos_t'(NOTCH_R))) u_rotor_r (
    .clock    (clock),
    .reset    (reset),
    .load     (load_en),
    .load_val (load_pos_r),
    .step     (rotate_r),
    .pos      (pos_r),
    .at_notch (notch_r)
  );

endmodule

// File: tb/tb_enigma_step_controller.sv
// Directed bench for enigma_step_controller: timing, double step, wrap, load arbitration, reset.
module tb_enigma_step_controller;
  import enigma_pkg::*;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned GAP    = SETTLE + 3;

  logic clock = 1'b0;
  logic reset;
  logic key_valid;
  logic key_ready;
  logic load;
  pos_t load_pos_l, load_pos_m, load_pos_r;
  pos_t pos_l, pos_m, pos_r;
  logic rotate_l, rotate_m, rotate_r;
  logic enc_strobe;
  logic busy;

  int checks   = 0;
  int failures = 0;

  enigma_step_controller #(
    .NOTCH_L(16), .NOTCH_M(4), .NOTCH_R(21), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .load       (load),
    .load_pos_l (load_pos_l),
    .load_pos_m (load_pos_m),
    .load_pos_r (load_pos_r),
    .pos_l      (pos_l),
    .pos_m      (pos_m),
    .pos_r      (pos_r),
    .rotate_l   (rotate_l),
    .rotate_m   (rotate_m),
    .rotate_r   (rotate_r),
    .enc_strobe (enc_strobe),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input pos_t el, input pos_t em, input pos_t er);
    chk({tag, "_l"}, pos_l, el);
    chk({tag, "_m"}, pos_m, em);
    chk({tag, "_r"}, pos_r, er);
  endtask

  task automatic do_load(input pos_t l, input pos_t m, input pos_t r);
    load = 1'b1; load_pos_l = l; load_pos_m = m; load_pos_r = r;
    tick();
    load = 1'b0;
  endtask

  // One full keypress from IDLE: checks every cycle of the k..k+5 timeline.
  task automatic do_key(input string tag, input pos_t el, input pos_t em, input pos_t er,
                        input logic rl, input logic rm, input logic rr);
    key_valid = 1'b1;
    #1;
    chk({tag, "_ready_k"}, key_ready, 1'b1);
    tick();
    key_valid = 1'b0;
    chk({tag, "_rot_l"}, rotate_l, rl);
    chk({tag, "_rot_m"}, rotate_m, rm);
    chk({tag, "_rot_r"}, rotate_r, rr);
    chk({tag, "_busy_step"}, busy, 1'b1);
    tick();
    chk_pos({tag, "_pos"}, el, em, er);
    chk({tag, "_rot_r_off"}, rotate_r, 1'b0);
    tick();
    chk({tag, "_enc_early"}, enc_strobe, 1'b0);
    tick();
    chk({tag, "_enc"}, enc_strobe, 1'b1);
    tick();
    chk({tag, "_enc_off"}, enc_strobe, 1'b0);
    chk({tag, "_ready_back"}, key_ready, 1'b1);
    chk({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    int strobes;
    int last;
    int cyc;
    int rot_m_cnt;
    int enc_seen;

    reset = 1'b1; key_valid = 1'b0; load = 1'b0;
    load_pos_l = LTR_A; load_pos_m = LTR_A; load_pos_r = LTR_A;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk_pos("rst_pos", LTR_A, LTR_A, LTR_A);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", key_ready, 1'b1);
    chk("rst_enc", enc_strobe, 1'b0);
    chk("rst_rot", {rotate_l, rotate_m, rotate_r}, 3'b000);

    do_key("k1", LTR_A, LTR_A, LTR_B, 1'b0, 1'b0, 1'b1);

    // Double step sequence ADU -> ADV -> AEW -> BFX.
    do_load(LTR_A, LTR_D, LTR_U);
    chk_pos("ld_adu", LTR_A, LTR_D, LTR_U);
    do_key("ds1", LTR_A, LTR_D, LTR_V, 1'b0, 1'b0, 1'b1);
    do_key("ds2", LTR_A, LTR_E, LTR_W, 1'b0, 1'b1, 1'b1);
    do_key("ds3", LTR_B, LTR_F, LTR_X, 1'b1, 1'b1, 1'b1);

    do_load(LTR_Z, LTR_Z, LTR_Z);
    do_key("wrap", LTR_Z, LTR_Z, LTR_A, 1'b0, 1'b0, 1'b1);

    // Load and key in the same IDLE cycle: load wins, no STEP.
    load = 1'b1; key_valid = 1'b1;
    load_pos_l = LTR_C; load_pos_m = LTR_D; load_pos_r = LTR_E;
    #1;
    chk("arb_ready", key_ready, 1'b0);
    tick();
    load = 1'b0; key_valid = 1'b0;
    chk("arb_busy", busy, 1'b0);
    chk("arb_rot_r", rotate_r, 1'b0);
    chk_pos("arb_pos", LTR_C, LTR_D, LTR_E);
    tick();
    chk("arb_busy2", busy, 1'b0);
    chk_pos("arb_pos2", LTR_C, LTR_D, LTR_E);

    // Load during SETTLE is ignored.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    load = 1'b1; load_pos_l = LTR_K; load_pos_m = LTR_K; load_pos_r = LTR_K;
    tick();
    load = 1'b0;
    chk_pos("settle_ld", LTR_C, LTR_D, LTR_F);
    tick();
    chk("settle_ld_enc", enc_strobe, 1'b1);
    tick();
    chk_pos("settle_ld_idle", LTR_C, LTR_D, LTR_F);
    chk("settle_ld_busy", busy, 1'b0);

    // Out-of-range preload values fold to A.
    do_load(pos_t'(30), LTR_C, pos_t'(31));
    chk_pos("ld_range", LTR_A, LTR_C, LTR_A);

    // Reset asserted during SETTLE.
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    chk_pos("pre_rst_pos", LTR_A, LTR_C, LTR_B);
    reset = 1'b1;
    #1;
    chk_pos("mid_rst_pos", LTR_A, LTR_A, LTR_A);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", key_ready, 1'b1);
    enc_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (enc_strobe) enc_seen++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (enc_strobe) enc_seen++;
    end
    chk("mid_rst_no_enc", enc_seen, 0);
    chk("mid_rst_idle", busy, 1'b0);
    do_key("post_rst", LTR_A, LTR_A, LTR_B, 1'b0, 1'b0, 1'b1);

    // Back-to-back keys with key_valid held.
    do_load(LTR_A, LTR_A, LTR_A);
    strobes = 0; last = -1; cyc = 0; rot_m_cnt = 0;
    key_valid = 1'b1;
    while (strobes < 26 && cyc < 400) begin
      tick();
      cyc++;
      if (rotate_m) rot_m_cnt++;
      if (enc_strobe) begin
        strobes++;
        if (last >= 0) chk("b2b_gap", cyc - last, GAP);
        last = cyc;
        if (strobes == 26) key_valid = 1'b0;
      end
    end
    chk("b2b_strobes", strobes, 26);
    tick();
    chk("b2b_idle", busy, 1'b0);
    tick();
    chk("b2b_no_extra", busy, 1'b0);
    chk_pos("b2b_pos", LTR_A, LTR_B, LTR_A);
    chk("b2b_rot_m", rot_m_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
